// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - register map, CTRL/STATUS bit positions and FSM states for counter_ctrl
package counter_ctrl_pkg;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_LOAD    = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_COUNT   = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_DOWN    = 3;
    localparam int CTRL_PRE_LSB = 8;

    localparam int STAT_MATCH   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - Wishbone classic slave bundle for counter_ctrl
interface counter_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/counter_core.sv
// rtl/counter_core.sv - count register with prioritised load/tick muxing and wrapping up/down step
module counter_core #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            la_load,
    input  logic [BITS-1:0] la_value,
    input  logic            wb_load,
    input  logic [BITS-1:0] wb_value,
    input  logic            tick,
    input  logic            down,
    output logic [BITS-1:0] count,
    output logic [BITS-1:0] count_next,
    output logic            tick_taken
);
    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic [BITS-1:0] count_q, count_d;

    // Loads shadow the tick so a load can never be mistaken for a compare match.
    always_comb begin
        tick_taken = tick && !la_load && !wb_load;
        count_d    = count_q;
        if (la_load) begin
            count_d = la_value;
        end else if (wb_load) begin
            count_d = wb_value;
        end else if (tick) begin
            count_d = down ? (count_q - ONE) : (count_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - Wishbone-mapped timer: bus decode, run/halt FSM, prescaler, compare and irq
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int PRE_W = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    counter_ctrl_if.slave   wbs,
    input  logic            la_load_i,
    input  logic [BITS-1:0] la_value_i,
    output logic [BITS-1:0] count_o,
    output logic            irq_o,
    output logic            running_o
);
    localparam logic [BITS-1:0] CTRL_MASK =
        (BITS'((1 << PRE_W) - 1) << CTRL_PRE_LSB) | BITS'(4'hF);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    state_e          state_q, state_d;
    logic [BITS-1:0] ctrl_q, ctrl_d, load_q, load_d, compare_q, compare_d;
    logic [BITS-1:0] dat_q, dat_d, rdata;
    logic [PRE_W-1:0] pre_q, pre_d, prescale;
    logic            ack_q, ack_d, match_q, match_d, hit_q, hit;
    logic            irq_q, irq_d, running_q, running_d, la_own_q;
    logic            access, wr, rd, wb_load, tick, tick_taken, w1c, oneshot_stop;
    logic [2:0]      off;
    logic [BITS-1:0] count_q, count_next;
    logic            unused_adr;

    assign unused_adr = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

    counter_core #(.BITS(BITS)) u_core (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .la_load    (la_load_i),
        .la_value   (la_value_i),
        .wb_load    (wb_load),
        .wb_value   (load_d),
        .tick       (tick),
        .down       (ctrl_q[CTRL_DOWN]),
        .count      (count_q),
        .count_next (count_next),
        .tick_taken (tick_taken)
    );

    always_comb begin
        // Accept only while ack is low, so a held strobe never double-acks back to back.
        access   = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
        wr       = access && wbs.wbs_we_i;
        rd       = access && !wbs.wbs_we_i;
        off      = wbs.wbs_adr_i[4:2];
        ack_d    = access;
        prescale = ctrl_q[CTRL_PRE_LSB +: PRE_W];
        tick     = (state_q == ST_RUN) && (pre_q == prescale);
        wb_load  = wr && (off == OFF_LOAD);
        w1c      = wr && (off == OFF_STATUS) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[STAT_MATCH];
        hit      = tick_taken && (count_next == compare_q);
        oneshot_stop = hit && ctrl_q[CTRL_ONESHOT];

        ctrl_d = ctrl_q;
        if (wr && (off == OFF_CTRL)) begin
            ctrl_d = byte_merge(ctrl_q, wbs.wbs_dat_i, wbs.wbs_sel_i) & CTRL_MASK;
        end
        if (oneshot_stop) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        load_d    = wb_load ? byte_merge(load_q, wbs.wbs_dat_i, wbs.wbs_sel_i) : load_q;
        compare_d = (wr && (off == OFF_COMPARE))
                  ? byte_merge(compare_q, wbs.wbs_dat_i, wbs.wbs_sel_i) : compare_q;
        match_d   = hit_q || (match_q && !w1c);
        irq_d     = match_q && ctrl_q[CTRL_IRQ_EN];

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctrl_q[CTRL_EN]) state_d = ST_RUN;
            ST_RUN: begin
                if (oneshot_stop)         state_d = ST_HALT;
                else if (!ctrl_q[CTRL_EN]) state_d = ST_IDLE;
            end
            ST_HALT: if (ctrl_q[CTRL_EN]) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);

        // Held at zero outside RUN, which also covers the clear on entry to RUN.
        if ((state_q != ST_RUN) || la_load_i || wb_load || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_ONE;
        end

        case (off)
            OFF_CTRL:    rdata = ctrl_q;
            OFF_LOAD:    rdata = load_q;
            OFF_COMPARE: rdata = compare_q;
            OFF_STATUS:  rdata = {{(BITS-3){1'b0}}, la_own_q, running_q, match_q};
            OFF_COUNT:   rdata = count_q;
            default:     rdata = '0;
        endcase
        dat_d = rd ? rdata : dat_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            load_q    <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
            hit_q     <= 1'b0;
            irq_q     <= 1'b0;
            running_q <= 1'b0;
            la_own_q  <= 1'b0;
            pre_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            hit_q     <= hit;
            irq_q     <= irq_d;
            running_q <= running_d;
            la_own_q  <= la_load_i;
            pre_q     <= pre_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign count_o       = count_q;
    assign irq_o         = irq_q;
    assign running_o     = running_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl with random register traffic and timed scenarios
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        la_load = 1'b0;
    logic [31:0] la_value = '0;
    logic [31:0] count;
    logic        irq, running;

    counter_ctrl_if bus ();

    counter_ctrl #(.BITS(32), .PRE_W(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (bus),
        .la_load_i  (la_load),
        .la_value_i (la_value),
        .count_o    (count),
        .irq_o      (irq),
        .running_o  (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } txn_t;

    txn_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_ctrl = '0, m_load = '0, m_cmp = '0, m_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (n & m) | (o & ~m);
    endfunction

    always @(negedge clk) begin : monitor
        txn_t t;
        if (bus.wbs_ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_ack: got ack with no outstanding access");
            end else begin
                t = sb.pop_front();
                if (t.is_read) check(t.name, bus.wbs_dat_o, t.exp);
            end
        end
    end

    task automatic wb_access(input bit we, input logic [2:0] off, input logic [31:0] data,
                             input logic [3:0] sel, input logic [31:0] exp, input string name);
        txn_t t;
        @(posedge clk);
        @(negedge clk);
        t.is_read = !we;
        t.exp     = exp;
        t.name    = name;
        sb.push_back(t);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = {27'd0, off, 2'b00};
        bus.wbs_dat_i = data;
        bus.wbs_sel_i = sel;
        @(posedge clk);
        #1;
        check({name, "_ack"}, {31'd0, bus.wbs_ack_o}, 32'd1);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data, input logic [3:0] sel);
        wb_access(1'b1, off, data, sel, 32'd0, $sformatf("wr%0d", off));
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
        wb_access(1'b0, off, 32'd0, 4'h0, exp, name);
    endtask

    // Count after j edges from the CTRL write: RUN is entered on edge 1, then one step per PRESCALE+1 edges.
    task automatic expect_run(input logic [31:0] start, input int p, input bit down,
                              input int jmax, input string name);
        logic [31:0] steps;
        for (int j = 1; j <= jmax; j++) begin
            @(posedge clk);
            #1;
            steps = 32'((j - 1) / (p + 1));
            check($sformatf("%s_j%0d", name, j), count, down ? start - steps : start + steps);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_ctrl;
            3'd1:    return m_load;
            3'd2:    return m_cmp;
            3'd4:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        int          op;
        logic [2:0]  off;
        logic [31:0] d;
        logic [3:0]  s;

        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) rd(3'(i), 32'd0, $sformatf("rst_reg%0d", i));

        // Random register traffic with EN held off, so the count only moves on LOAD writes.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            case (op)
                0: begin
                    d[0] = 1'b0;
                    wr(OFF_CTRL, d, s);
                    m_ctrl = tb_merge(m_ctrl, d, s) & 32'h0000_FF0F;
                end
                1: begin
                    wr(OFF_LOAD, d, s);
                    m_load  = tb_merge(m_load, d, s);
                    m_count = m_load;
                end
                2: begin
                    wr(OFF_COMPARE, d, s);
                    m_cmp = tb_merge(m_cmp, d, s);
                end
                3: begin
                    off = 3'($urandom_range(3, 7));
                    wr(off, d, s);
                end
                default: begin
                    off = 3'($urandom_range(0, 7));
                    rd(off, model_read(off), $sformatf("rand_rd%0d", off));
                end
            endcase
        end
        for (int i = 0; i < 8; i++) rd(3'(i), model_read(3'(i)), $sformatf("rand_final%0d", i));
        wr(OFF_CTRL, 32'd0, 4'hF);

        // Up-count to compare, sticky MATCH, registered irq.
        wr(OFF_LOAD, 32'h10, 4'hF);
        wr(OFF_COMPARE, 32'h13, 4'hF);
        wr(OFF_CTRL, 32'h05, 4'hF);
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("cmp_count_j%0d", j), count, 32'h10 + 32'(j - 1));
            check($sformatf("cmp_irq_j%0d", j), {31'd0, irq}, (j >= 6) ? 32'd1 : 32'd0);
        end
        wr(OFF_CTRL, 32'd0, 4'hF);
        rd(OFF_STATUS, 32'h1, "match_sticky");
        wr(OFF_STATUS, 32'h1, 4'h1);
        rd(OFF_STATUS, 32'h0, "match_w1c");

        // Prescaled wrap upward, then single-step wrap downward.
        wr(OFF_LOAD, 32'hFFFF_FFFE, 4'hF);
        wr(OFF_CTRL, 32'h0301, 4'hF);
        expect_run(32'hFFFF_FFFE, 3, 1'b0, 9, "wrap_up");
        wr(OFF_CTRL, 32'd0, 4'hF);
        wr(OFF_LOAD, 32'h1, 4'hF);
        wr(OFF_CTRL, 32'h09, 4'hF);
        expect_run(32'h1, 0, 1'b1, 4, "wrap_dn");
        wr(OFF_CTRL, 32'd0, 4'hF);

        // One-shot halts at compare and clears EN; EN write resumes from HALT.
        wr(OFF_COMPARE, 32'h5, 4'hF);
        wr(OFF_LOAD, 32'h0, 4'hF);
        wr(OFF_CTRL, 32'h03, 4'hF);
        expect_run(32'h0, 0, 1'b0, 6, "oneshot");
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("halt_count%0d", j), count, 32'h5);
            check($sformatf("halt_running%0d", j), {31'd0, running}, 32'd0);
        end
        rd(OFF_CTRL, 32'h2, "halt_ctrl");
        rd(OFF_STATUS, 32'h1, "halt_status");
        wr(OFF_CTRL, 32'h01, 4'hF);
        expect_run(32'h5, 0, 1'b0, 4, "resume");
        wr(OFF_CTRL, 32'd0, 4'hF);
        wr(OFF_STATUS, 32'h1, 4'h1);

        // LA load beats a same-cycle WB LOAD and tick.
        wr(OFF_LOAD, 32'h100, 4'hF);
        wr(OFF_CTRL, 32'h01, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        la_value = 32'hA5A5_A5A5;
        la_load  = 1'b1;
        wr(OFF_LOAD, 32'h1, 4'hF);
        check("la_priority", count, 32'hA5A5_A5A5);
        rd(OFF_STATUS, 32'h6, "la_own");
        rd(OFF_COUNT, 32'hA5A5_A5A5, "la_count");
        rd(OFF_LOAD, 32'h1, "la_load_reg");
        la_load = 1'b0;
        wr(OFF_CTRL, 32'd0, 4'hF);

        // W1C coinciding with a fresh match keeps MATCH set.
        wr(OFF_STATUS, 32'h1, 4'h1);
        wr(OFF_LOAD, 32'h0, 4'hF);
        wr(OFF_COMPARE, 32'h3, 4'hF);
        wr(OFF_CTRL, 32'h01, 4'hF);
        repeat (3) @(posedge clk);
        wr(OFF_STATUS, 32'h1, 4'h1);
        rd(OFF_STATUS, 32'h3, "w1c_vs_match");
        rd(3'd7, 32'h0, "off7");

        // Loading the compare value must not raise MATCH.
        wr(OFF_CTRL, 32'd0, 4'hF);
        wr(OFF_STATUS, 32'h1, 4'h1);
        wr(OFF_COMPARE, 32'h40, 4'hF);
        wr(OFF_CTRL, 32'hFF01, 4'hF);
        wr(OFF_LOAD, 32'h40, 4'hF);
        rd(OFF_STATUS, 32'h2, "load_no_match");
        wr(OFF_CTRL, 32'd0, 4'hF);

        // Asynchronous reset while counting with irq high and a read pending.
        wr(OFF_LOAD, 32'h1230, 4'hF);
        wr(OFF_COMPARE, 32'h1232, 4'hF);
        wr(OFF_CTRL, 32'h05, 4'hF);
        expect_run(32'h1230, 0, 1'b0, 5, "pre_rst");
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = {27'd0, OFF_COUNT, 2'b00};
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("arst_running", {31'd0, running}, 32'd0);
        check("arst_dat", bus.wbs_dat_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        rd(OFF_COUNT, 32'd0, "post_rst_count");
        rd(OFF_CTRL, 32'd0, "post_rst_ctrl");
        rd(OFF_STATUS, 32'd0, "post_rst_status");

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter BITS, 32, width of the counter and the compare/load registers; only 32 is supported.
REQ-002 Parameter PRE_W, 8, width of the prescaler field.
REQ-003 Port wb_clk_i  in  1  single clock; all state is on its rising edge.
REQ-004 Port wb_rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 Ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-006 Port wbs_sel_i  in  4  byte strobes; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-007 Port wbs_ack_o  out  1  ack pulse; wbs_dat_o  out  32  read data.
REQ-008 Port la_load_i  in  1  logic-analyzer load request; la_value_i  in  32  LA load value.
REQ-009 Port count_o  out  32  current count; irq_o  out  1  compare interrupt; running_o  out  1  high in RUN.

Function
REQ-010 Bus access (valid = cyc & stb) SHALL be acked exactly one cycle after valid rises, with a one-cycle ack pulse and no ack while ack is already high.
REQ-011 Register decode SHALL use wbs_adr_i[4:2]: 0 CTRL, 1 LOAD, 2 COMPARE, 3 STATUS, 4 COUNT (read-only); other offsets SHALL read 0, ignore writes, and still ack.
REQ-012 CTRL fields SHALL be: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bit3 DOWN, bits[8+PRE_W-1:8] PRESCALE.
REQ-013 Writes to CTRL, LOAD and COMPARE SHALL honour wbs_sel_i per byte.
REQ-014 STATUS SHALL be: bit0 MATCH (sticky, write-1-to-clear), bit1 RUNNING, bit2 LA_OWN (la_load_i registered).
REQ-015 A write to LOAD SHALL store the value and load it into the count on the ack cycle.
REQ-016 The FSM SHALL have states IDLE, RUN and HALT.
REQ-017 IDLE->RUN when EN=1; RUN->IDLE when EN=0; RUN->HALT on a match with ONESHOT=1, which also clears EN.
REQ-018 HALT->RUN when software writes EN=1, otherwise HALT SHALL hold.
REQ-019 In RUN the prescaler SHALL emit a tick every PRESCALE+1 cycles; the prescaler SHALL be cleared on entering RUN and on any load.
REQ-020 On a tick the count SHALL increment (DOWN=0) or decrement (DOWN=1), wrapping modulo 2^32 (0xFFFFFFFF+1=0, 0-1=0xFFFFFFFF).
REQ-021 Count update priority SHALL be: LA load (la_load_i=1) > WB LOAD write > tick; a lower-priority event in the same cycle SHALL be dropped.
REQ-022 A match occurs when a tick produces a count equal to COMPARE; a load to the COMPARE value SHALL NOT match.
REQ-023 A match SHALL set MATCH one cycle after the tick; a match and a W1C in the same cycle SHALL leave MATCH set.
REQ-024 irq_o SHALL be registered as MATCH & IRQ_EN, i.e. one cycle after MATCH.
REQ-025 A read of COUNT SHALL return the count as sampled on the valid cycle.

Reset
REQ-026 Asserting wb_rst_ni SHALL immediately clear all state: FSM=IDLE, CTRL=0, LOAD=0, COMPARE=0, MATCH=0, count=0, prescaler=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, running_o=0.
REQ-027 Reset asserted mid-transaction SHALL drop the pending ack; after deassertion the first action SHALL be a fresh ack on a new valid.

Structure
REQ-028 Package counter_ctrl_pkg SHALL hold the register offsets, CTRL bit positions and the FSM state enum.
REQ-029 Sub-module counter_core SHALL hold the count register, its load/tick/direction muxing and wrap arithmetic; counter_ctrl SHALL hold the bus, FSM, prescaler, compare and interrupt logic.

Verification
REQ-030 LOAD=0x10, COMPARE=0x13, CTRL=0x05 (EN, IRQ_EN, PRESCALE=0) -> count 0x11,0x12,0x13 on consecutive cycles; MATCH=1 the cycle after 0x13; irq_o=1 one cycle later; count continues to 0x14.
REQ-031 LOAD=0xFFFFFFFE, CTRL EN with PRESCALE=3 -> count 0xFFFFFFFF after 4 cycles and 0x00000000 after 8; with DOWN=1 from 0x1 -> 0x0 then 0xFFFFFFFF.
REQ-032 ONESHOT=1, COMPARE=0x5, LOAD=0x0 -> after reaching 0x5: HALT, EN reads 0, count holds at 0x5 for 20 cycles, running_o=0.
REQ-033 la_load_i=1 with la_value_i=0xA5A5A5A5 in the same cycle as a WB LOAD write of 0x1 and a tick -> count=0xA5A5A5A5 and STATUS.LA_OWN=1.
REQ-034 W1C of MATCH in the same cycle as a new match -> MATCH stays 1; a read of offset 7 returns 0 and acks in 1 cycle.
REQ-035 wb_rst_ni pulsed low while counting at 0x1234 and while a read is in flight -> count=0, irq_o=0, wbs_ack_o=0 immediately, and no stale ack after release.
